// File: rtl/otter_mem2_arbiter.sv
// otter_mem2_arbiter: arbitrates OTTER memory port 2 between the MEM stage and the UART programmer.
// Define ARB_FAIR_EN to let a starved CPU beat a pending programmer write after MAX_WAIT stalls.
module otter_mem2_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [31:0]       CPU_DIN,
    input  logic [1:0]        CPU_SIZE,
    input  logic              CPU_SIGN,
    output logic              CPU_STALL,
    output logic              CPU_RVALID,
    output logic [31:0]       CPU_DOUT,
    input  logic              PROG_REQ,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [31:0]       PROG_DATA,
    input  logic              PROG_LOCK,
    output logic              PROG_ACK,
    output logic              PROG_OVF,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [31:0]       MEM_DIN2,
    output logic              MEM_WRITE2,
    output logic              MEM_READ2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [31:0]       MEM_DOUT2
);
    typedef enum logic [1:0] {IDLE, RD_PEND, LOCKED} state_t;

    state_t            state, state_nx;
    logic              pending, ovf, capture;
    logic [ADDR_W-1:0] pend_addr;
    logic [31:0]       pend_data;
    logic              prog_win, cpu_win, cpu_load, cpu_first;

`ifdef ARB_FAIR_EN
    logic [2:0] wait_cnt;
    assign cpu_first = ~PROG_LOCK & (int'(wait_cnt) >= MAX_WAIT);
    always_ff @(posedge CLK) begin
        if (!RST)
            wait_cnt <= '0;
        else if (cpu_win)
            wait_cnt <= '0;
        else if (CPU_STALL && !PROG_LOCK && wait_cnt != 3'd7)
            wait_cnt <= wait_cnt + 3'd1;
    end
`else
    assign cpu_first = 1'b0;
`endif

    // Everything is gated by RST so the port is silent while reset is held.
    assign prog_win = RST & pending & ~(cpu_first & CPU_REQ);
    assign cpu_win  = RST & CPU_REQ & ~PROG_LOCK & ~prog_win;
    assign cpu_load = cpu_win & ~CPU_WE;
    // An issuing entry frees the slot in the same cycle, so a new pulse may refill it.
    assign capture  = PROG_REQ & (~pending | prog_win);

    always_comb begin
        state_nx = IDLE;
        if (PROG_LOCK)
            state_nx = LOCKED;
        else if (cpu_load)
            state_nx = RD_PEND;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            pending   <= 1'b0;
            ovf       <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            state   <= state_nx;
            pending <= capture | (pending & ~prog_win);
            if (capture) begin
                pend_addr <= PROG_ADDR;
                pend_data <= PROG_DATA;
            end
            if (PROG_REQ && pending && !prog_win)
                ovf <= 1'b1;
        end
    end

    assign CPU_STALL  = RST & CPU_REQ & ~cpu_win;
    assign CPU_RVALID = RST & (state == RD_PEND);
    assign CPU_DOUT   = CPU_RVALID ? MEM_DOUT2 : '0;
    assign PROG_ACK   = prog_win;
    assign PROG_OVF   = RST & ovf;
    assign MEM_WRITE2 = prog_win | (cpu_win & CPU_WE);
    assign MEM_READ2  = cpu_load;
    assign MEM_ADDR2  = prog_win ? pend_addr : cpu_win ? CPU_ADDR : '0;
    assign MEM_DIN2   = prog_win ? pend_data : cpu_win ? CPU_DIN : '0;
    assign MEM_SIZE   = prog_win ? 2'b10 : cpu_win ? CPU_SIZE : 2'b00;
    assign MEM_SIGN   = cpu_win & CPU_SIGN;
endmodule

// File: tb/tb_otter_mem2_arbiter.sv
// tb_otter_mem2_arbiter: scoreboard bench; stimulus queues expected port-2 transactions,
// load data and per-cycle control flags, and a negedge monitor pops and compares them.
module tb_otter_mem2_arbiter;
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
    } txn_t;
    typedef struct {
        string      name;
        logic [4:0] mask;
        logic [4:0] val;
    } ctl_t;

    localparam logic [4:0] ALL = 5'h1F;

    logic        CLK = 1'b0, RST = 1'b0;
    logic        CPU_REQ = 1'b0, CPU_WE = 1'b0, CPU_SIGN = 1'b0;
    logic [31:0] CPU_ADDR = '0, CPU_DIN = '0;
    logic [1:0]  CPU_SIZE = '0;
    logic        CPU_STALL, CPU_RVALID;
    logic [31:0] CPU_DOUT;
    logic        PROG_REQ = 1'b0, PROG_LOCK = 1'b0;
    logic [31:0] PROG_ADDR = '0, PROG_DATA = '0;
    logic        PROG_ACK, PROG_OVF;
    logic [31:0] MEM_ADDR2, MEM_DIN2;
    logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
    logic [1:0]  MEM_SIZE;
    logic [31:0] MEM_DOUT2 = '0;

    txn_t        mem_q[$];
    logic [31:0] rd_q[$];
    ctl_t        ctl_q[$];
    txn_t        act_txn, exp_txn;
    logic [4:0]  act_ctl;
    logic [31:0] exp_rd;
    ctl_t        exp_ctl;
    int          tests = 0, fails = 0;
    logic        done = 1'b0;

    otter_mem2_arbiter #(.MAX_WAIT(4), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN), .CPU_STALL(CPU_STALL),
        .CPU_RVALID(CPU_RVALID), .CPU_DOUT(CPU_DOUT),
        .PROG_REQ(PROG_REQ), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
        .PROG_LOCK(PROG_LOCK), .PROG_ACK(PROG_ACK), .PROG_OVF(PROG_OVF),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        case (a)
            32'h100: return 32'hDEADBEEF;
            32'h104: return 32'hCAFEF00D;
            default: return 32'h0BAD0BAD;
        endcase
    endfunction

    // Synchronous-read memory: data appears one cycle after MEM_READ2.
    always @(posedge CLK) if (MEM_READ2) MEM_DOUT2 <= rdata(MEM_ADDR2);

    assign act_txn = {MEM_READ2, MEM_WRITE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN};
    assign act_ctl = {CPU_STALL, PROG_ACK, CPU_RVALID, PROG_OVF, MEM_READ2 | MEM_WRITE2};

    always @(negedge CLK) begin
        if (MEM_READ2 || MEM_WRITE2) begin
            tests++;
            if (mem_q.size() == 0) begin
                fails++;
                $display("FAIL mem_txn: got %h required none", act_txn);
            end else begin
                exp_txn = mem_q.pop_front();
                if (act_txn !== exp_txn) begin
                    fails++;
                    $display("FAIL mem_txn: got %h required %h", act_txn, exp_txn);
                end
            end
        end
        if (CPU_RVALID) begin
            tests++;
            if (rd_q.size() == 0) begin
                fails++;
                $display("FAIL rdata: got %h required none", CPU_DOUT);
            end else begin
                exp_rd = rd_q.pop_front();
                if (CPU_DOUT !== exp_rd) begin
                    fails++;
                    $display("FAIL rdata: got %h required %h", CPU_DOUT, exp_rd);
                end
            end
        end else begin
            tests++;
            if (CPU_DOUT !== 32'h0) begin
                fails++;
                $display("FAIL dout_idle: got %h required 0", CPU_DOUT);
            end
        end
        if (ctl_q.size() != 0) begin
            exp_ctl = ctl_q.pop_front();
            tests++;
            if ((act_ctl & exp_ctl.mask) !== (exp_ctl.val & exp_ctl.mask)) begin
                fails++;
                $display("FAIL %s: got stall/ack/rvalid/ovf/busy=%b required %b (mask %b)",
                         exp_ctl.name, act_ctl, exp_ctl.val, exp_ctl.mask);
            end
        end
        if (done) begin
            tests++;
            if (mem_q.size() != 0 || rd_q.size() != 0 || ctl_q.size() != 0) begin
                fails++;
                $display("FAIL drain: got %0d/%0d/%0d left required 0/0/0",
                         mem_q.size(), rd_q.size(), ctl_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu(input logic req, we, input logic [31:0] a, d,
                       input logic [1:0] s, input logic sg);
        CPU_REQ = req; CPU_WE = we; CPU_ADDR = a; CPU_DIN = d; CPU_SIZE = s; CPU_SIGN = sg;
    endtask

    task automatic prog(input logic req, input logic [31:0] a, d);
        PROG_REQ = req; PROG_ADDR = a; PROG_DATA = d;
    endtask

    task automatic emem(input logic rd, wr, input logic [31:0] a, d,
                        input logic [1:0] s, input logic sg);
        mem_q.push_back({rd, wr, a, d, s, sg});
    endtask

    task automatic ectl(input string n, input logic [4:0] m, input logic [4:0] v);
        ctl_t c;
        c.name = n; c.mask = m; c.val = v;
        ctl_q.push_back(c);
    endtask

    initial begin
        tick;
        for (int i = 0; i < 3; i++) begin
            cpu(1, 0, 32'h100, 0, 2'b10, 0);
            ectl("reset_quiet", ALL, 5'b00000);
            tick;
        end
        RST = 1'b1;
        emem(1, 0, 32'h100, 0, 2'b10, 0); rd_q.push_back(32'hDEADBEEF);
        ectl("first_grant", ALL, 5'b00001);
        tick;
        cpu(1, 0, 32'h104, 0, 2'b01, 1);
        emem(1, 0, 32'h104, 0, 2'b01, 1); rd_q.push_back(32'hCAFEF00D);
        ectl("b2b_load", ALL, 5'b00101);
        tick;
        cpu(0, 0, 0, 0, 2'b00, 0);
        ectl("b2b_rvalid2", ALL, 5'b00100);
        tick;
        ectl("idle", ALL, 5'b00000);
        tick;
        prog(1, 32'h8, 32'h12345678);
        ectl("prog_capture", ALL, 5'b00000);
        tick;
        prog(0, 0, 0);
        cpu(1, 1, 32'h200, 32'h55AA55AA, 2'b10, 0);
        emem(0, 1, 32'h8, 32'h12345678, 2'b10, 0);
        ectl("prog_first", ALL, 5'b11001);
        tick;
        emem(0, 1, 32'h200, 32'h55AA55AA, 2'b10, 0);
        ectl("cpu_store", ALL, 5'b00001);
        tick;
        cpu(0, 0, 0, 0, 2'b00, 0);
        prog(1, 32'hC, 32'h11111111);
        ectl("pulse_a", ALL, 5'b00000);
        tick;
        prog(1, 32'h10, 32'h22222222);
        emem(0, 1, 32'hC, 32'h11111111, 2'b10, 0);
        ectl("pulse_b_refill", ALL, 5'b01001);
        tick;
        prog(0, 0, 0);
        emem(0, 1, 32'h10, 32'h22222222, 2'b10, 0);
        ectl("pulse_b_issue", ALL, 5'b01001);
        tick;
        cpu(1, 0, 32'h100, 0, 2'b10, 0);
        emem(1, 0, 32'h100, 0, 2'b10, 0); rd_q.push_back(32'hDEADBEEF);
        ectl("load_before_lock", ALL, 5'b00001);
        tick;
        cpu(0, 0, 0, 0, 2'b00, 0);
        PROG_LOCK = 1'b1;
        ectl("lock_keeps_rvalid", ALL, 5'b00100);
        tick;
        for (int i = 0; i < 10; i++) begin
            cpu(1, 0, 32'h300, 0, 2'b10, 0);
            prog(i % 4 == 0, 32'h20 + i, 32'hA0000000 + i);
            if (i % 4 == 1) begin
                emem(0, 1, 32'h20 + i - 1, 32'hA0000000 + i - 1, 2'b10, 0);
                ectl("locked_ack", ALL, 5'b11001);
            end else
                ectl("locked_stall", ALL, 5'b10000);
            tick;
        end
        PROG_LOCK = 1'b0;
        prog(0, 0, 0);
        cpu(1, 1, 32'h304, 32'h77, 2'b10, 0);
        emem(0, 1, 32'h304, 32'h77, 2'b10, 0);
        ectl("unlock_grant", ALL, 5'b00001);
        tick;
        cpu(0, 0, 0, 0, 2'b00, 0);
`ifdef ARB_FAIR_EN
        prog(1, 32'h40, 32'hB0);
        ectl("fair_fill", ALL, 5'b00000);
        tick;
        for (int i = 1; i <= 4; i++) begin
            cpu(1, 1, 32'h500, 32'hC0DE, 2'b10, 0);
            prog(1, 32'h40 + i, 32'hB0 + i);
            emem(0, 1, 32'h40 + i - 1, 32'hB0 + i - 1, 2'b10, 0);
            ectl("fair_starve", ALL, 5'b11001);
            tick;
        end
        prog(1, 32'h45, 32'hB5);
        emem(0, 1, 32'h500, 32'hC0DE, 2'b10, 0);
        ectl("fair_cpu_wins", ALL, 5'b00001);
        tick;
        cpu(0, 0, 0, 0, 2'b00, 0);
        prog(0, 0, 0);
        emem(0, 1, 32'h44, 32'hB4, 2'b10, 0);
        ectl("fair_retained_ovf", ALL, 5'b01011);
        tick;
        prog(1, 32'h50, 32'hD0);
        ectl("ovf_sticky", ALL, 5'b00010);
        tick;
        prog(0, 0, 0);
        cpu(1, 1, 32'h504, 32'h1, 2'b10, 0);
        emem(0, 1, 32'h50, 32'hD0, 2'b10, 0);
        ectl("fair_cnt_cleared", ALL, 5'b11011);
        tick;
        emem(0, 1, 32'h504, 32'h1, 2'b10, 0);
        ectl("fair_store_after", ALL, 5'b00011);
        tick;
        cpu(0, 0, 0, 0, 2'b00, 0);
        ectl("ovf_still", ALL, 5'b00010);
        tick;
`else
        ectl("no_ovf", ALL, 5'b00000);
        tick;
`endif
        cpu(1, 0, 32'h104, 0, 2'b10, 0);
        emem(1, 0, 32'h104, 0, 2'b10, 0);
        ectl("load_before_reset", 5'b11101, 5'b00001);
        tick;
        RST = 1'b0;
        cpu(0, 0, 0, 0, 2'b00, 0);
        ectl("reset_drops_read", ALL, 5'b00000);
        tick;
        RST = 1'b1;
        ectl("after_reset", ALL, 5'b00000);
        tick;
        done = 1'b1;
    end
endmodule
